// File: rtl/water_pkg.sv
// Shared definitions for the tank level probe front end.
//   - fault_state_t : states of the probe-combination fault filter
//   - WATER_*       : encodings presented on encoded_water
//   - DEFAULT_*     : default debounce / persistence depths and counter width
//   - combo_valid   : 1 when {high,mid,low} is a physically possible wet pattern
//   - encode_level  : maps a valid {high,mid,low} pattern to its 2-bit level code
package water_pkg;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULT   = 2'd2,
        RECOVER = 2'd3
    } fault_state_t;

    localparam logic [1:0] WATER_EMPTY = 2'b00;
    localparam logic [1:0] WATER_LOW   = 2'b01;
    localparam logic [1:0] WATER_MID   = 2'b10;
    localparam logic [1:0] WATER_HIGH  = 2'b11;

    localparam int DEFAULT_DEBOUNCE_SAMPLES = 32'd4;
    localparam int DEFAULT_FAULT_SAMPLES    = 32'd3;
    localparam int DEFAULT_CNT_W            = 32'd4;

    // A higher probe can only be wet when every probe below it is wet too.
    function automatic logic combo_valid(input logic [2:0] hml);
        return !((hml[1] && !hml[0]) || (hml[2] && !hml[1]));
    endfunction

    // Highest wet probe wins; only meaningful for valid patterns.
    function automatic logic [1:0] encode_level(input logic [2:0] hml);
        logic [1:0] code;
        if (hml[2]) begin
            code = WATER_HIGH;
        end else if (hml[1]) begin
            code = WATER_MID;
        end else if (hml[0]) begin
            code = WATER_LOW;
        end else begin
            code = WATER_EMPTY;
        end
        return code;
    endfunction

endpackage

// File: rtl/probe_debouncer.sv
// One probe channel: 2-flop synchroniser, sample-tick debounce counter and
// the resulting stable bit.
// Ports:
//   clock, reset_n  : system clock, asynchronous active-low reset
//   sample_tick     : debounce evaluation enable (one tick per asserted clock)
//   raw             : asynchronous probe input, 1 = wet
//   stable          : registered debounced value
//   stable_next     : value stable will take at the next clock edge; lets the
//                     fault filter judge the combination after this tick
module probe_debouncer
    import water_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = DEFAULT_DEBOUNCE_SAMPLES,
    parameter int CNT_W            = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sample_tick,
    input  logic raw,
    output logic stable,
    output logic stable_next
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_SAMPLES);

    logic [1:0]       sync_r;
    logic             stable_r;
    logic             stable_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Two-flop synchroniser for the asynchronous probe input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // Debounce decision: count consecutive disagreeing ticks, flip on the limit.
    always_comb begin
        stable_next_s = stable_r;
        cnt_next_s    = cnt_r;
        if (sample_tick) begin
            if (sync_r[1] == stable_r) begin
                cnt_next_s = '0;
            end else if ((cnt_r + CNT_ONE) == CNT_LIMIT) begin
                stable_next_s = ~stable_r;
                cnt_next_s    = '0;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            stable_r <= stable_next_s;
            cnt_r    <= cnt_next_s;
        end
    end

    assign stable      = stable_r;
    assign stable_next = stable_next_s;

endmodule

// File: rtl/water_sensor_acquisition.sv
// Tank level probe front end: debounces the low/mid/high probes, filters
// impossible probe combinations through a persistence state machine and
// publishes the level code plus a change pulse.
// Ports:
//   clock, reset_n       : system clock, asynchronous active-low reset
//   sample_tick          : slow sample enable; each asserted clock is one tick
//   *_water_level_raw    : raw probe inputs, 1 = wet
//   clear_fault          : fault acknowledge (only used with FAULT_LATCH_EN)
//   *_water_level        : debounced probe bits
//   conflicting_values   : 1 while the filter is in FAULT or RECOVER
//   encoded_water        : 00 empty, 01 low, 10 mid, 11 high
//   level_changed        : one-clock pulse when encoded_water changes
// Build option: define FAULT_LATCH_EN to make FAULT sticky until clear_fault
// is pulsed while the combination is valid.
module water_sensor_acquisition
    import water_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = DEFAULT_DEBOUNCE_SAMPLES,
    parameter int FAULT_SAMPLES    = DEFAULT_FAULT_SAMPLES,
    parameter int CNT_W            = DEFAULT_CNT_W
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sample_tick,
    input  logic       low_water_level_raw,
    input  logic       mid_water_level_raw,
    input  logic       high_water_level_raw,
    input  logic       clear_fault,
    output logic       low_water_level,
    output logic       mid_water_level,
    output logic       high_water_level,
    output logic       conflicting_values,
    output logic [1:0] encoded_water,
    output logic       level_changed
);

    localparam logic [CNT_W-1:0] PERS_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PERS_LIMIT = CNT_W'(FAULT_SAMPLES);

    logic [2:0]       raw_s;
    logic [2:0]       stable_s;
    logic [2:0]       stable_next_s;
    logic             valid_next_s;
    logic             leave_fault_s;
    fault_state_t     state_r;
    fault_state_t     state_next_s;
    logic [CNT_W-1:0] pers_r;
    logic [CNT_W-1:0] pers_next_s;
    logic [1:0]       enc_r;
    logic [1:0]       enc_next_s;
    logic             conflict_r;
    logic             changed_r;

    assign raw_s = {high_water_level_raw, mid_water_level_raw, low_water_level_raw};

    probe_debouncer #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES), .CNT_W(CNT_W)) u_low (
        .clock       (clock),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .raw         (raw_s[0]),
        .stable      (stable_s[0]),
        .stable_next (stable_next_s[0])
    );

    probe_debouncer #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES), .CNT_W(CNT_W)) u_mid (
        .clock       (clock),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .raw         (raw_s[1]),
        .stable      (stable_s[1]),
        .stable_next (stable_next_s[1])
    );

    probe_debouncer #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES), .CNT_W(CNT_W)) u_high (
        .clock       (clock),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .raw         (raw_s[2]),
        .stable      (stable_s[2]),
        .stable_next (stable_next_s[2])
    );

    // Judge the combination the probes will hold after this tick's debounce.
    assign valid_next_s = combo_valid(stable_next_s);

`ifdef FAULT_LATCH_EN
    // Sticky fault: only an acknowledge on a valid combination releases it.
    assign leave_fault_s = clear_fault & valid_next_s;
`else
    logic clear_fault_unused_s;
    assign clear_fault_unused_s = clear_fault;
    assign leave_fault_s        = sample_tick & valid_next_s;
`endif

    // Fault filter next-state and persistence counter.
    always_comb begin
        state_next_s = state_r;
        pers_next_s  = pers_r;
        case (state_r)
            OK: begin
                if (sample_tick && !valid_next_s) begin
                    if (PERS_ONE == PERS_LIMIT) begin
                        state_next_s = FAULT;
                        pers_next_s  = '0;
                    end else begin
                        state_next_s = SUSPECT;
                        pers_next_s  = PERS_ONE;
                    end
                end else begin
                    state_next_s = OK;
                end
            end
            SUSPECT: begin
                if (!sample_tick) begin
                    state_next_s = SUSPECT;
                end else if (valid_next_s) begin
                    state_next_s = OK;
                    pers_next_s  = '0;
                end else if ((pers_r + PERS_ONE) == PERS_LIMIT) begin
                    state_next_s = FAULT;
                    pers_next_s  = '0;
                end else begin
                    pers_next_s = pers_r + PERS_ONE;
                end
            end
            FAULT: begin
                if (leave_fault_s) begin
                    if (PERS_ONE == PERS_LIMIT) begin
                        state_next_s = OK;
                        pers_next_s  = '0;
                    end else begin
                        state_next_s = RECOVER;
                        pers_next_s  = PERS_ONE;
                    end
                end else begin
                    state_next_s = FAULT;
                end
            end
            RECOVER: begin
                if (!sample_tick) begin
                    state_next_s = RECOVER;
                end else if (!valid_next_s) begin
                    state_next_s = FAULT;
                    pers_next_s  = '0;
                end else if ((pers_r + PERS_ONE) == PERS_LIMIT) begin
                    state_next_s = OK;
                    pers_next_s  = '0;
                end else begin
                    pers_next_s = pers_r + PERS_ONE;
                end
            end
            default: begin
                state_next_s = OK;
                pers_next_s  = '0;
            end
        endcase
    end

    // Level code follows the probes only while the filter ends up in OK.
    always_comb begin
        enc_next_s = enc_r;
        if (state_next_s == OK) begin
            enc_next_s = encode_level(stable_next_s);
        end else begin
            enc_next_s = enc_r;
        end
    end

    // Filter state and registered outputs; a change pulse is never extended.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= OK;
            pers_r     <= '0;
            enc_r      <= WATER_EMPTY;
            conflict_r <= 1'b0;
            changed_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pers_r     <= pers_next_s;
            enc_r      <= enc_next_s;
            conflict_r <= (state_next_s == FAULT) || (state_next_s == RECOVER);
            changed_r  <= (enc_next_s != enc_r) && !changed_r;
        end
    end

    assign low_water_level    = stable_s[0];
    assign mid_water_level    = stable_s[1];
    assign high_water_level   = stable_s[2];
    assign conflicting_values = conflict_r;
    assign encoded_water      = enc_r;
    assign level_changed      = changed_r;

endmodule
